// File: rtl/user_write_arbiter.sv
// user_write_arbiter: round-robin write arbiter tagging grants with port-index user IDs;
// forwards only AUTH_ID writes. Define VIOLATION_LOG_EN to add the denied-write log.
module user_write_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W = 8,
    parameter logic [1:0] AUTH_ID = 2'h2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [1:0]                out_usr_id,
    output logic [DATA_W-1:0]         out_data,
    output logic                      deny_pulse,
    output logic                      busy
`ifdef VIOLATION_LOG_EN
    ,
    output logic [7:0]                viol_count,
    output logic [1:0]                last_viol_id,
    input  logic                      viol_clr
`endif
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SEND = 2'd1;
    localparam logic [1:0] DENY = 2'd2;

    logic [1:0] state;
    logic [1:0] rr_ptr;
    logic [1:0] win;
    logic       any;
    logic       grant;
    logic       auth;

    // Scan downward so the lowest offset from rr_ptr is the last (winning) match.
    always_comb begin
        win = '0;
        for (int k = 3; k >= 0; k--)
            if (req_valid[rr_ptr + 2'(k)]) win = rr_ptr + 2'(k);
    end

    assign any        = |req_valid;
    assign grant      = (state == IDLE) && any;
    assign auth       = (win == AUTH_ID);
    assign req_ready  = grant ? NUM_REQ'(1) << win : '0;
    assign out_valid  = (state == SEND);
    assign deny_pulse = (state == DENY);
    assign busy       = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            out_usr_id <= '0;
            out_data   <= '0;
        end else begin
            case (state)
                IDLE: if (any) begin
                    out_usr_id <= win;
                    out_data   <= auth ? req_data[int'(win)*DATA_W +: DATA_W] : '0;
                    rr_ptr     <= win + 2'd1;
                    state      <= auth ? SEND : DENY;
                end
                SEND: if (out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef VIOLATION_LOG_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            viol_count   <= '0;
            last_viol_id <= '0;
        end else begin
            if (viol_clr) viol_count <= '0;
            else if (grant && !auth && viol_count != 8'hFF) viol_count <= viol_count + 8'd1;
            if (grant && !auth) last_viol_id <= win;
        end
    end
`endif
endmodule

// File: tb/tb_user_write_arbiter.sv
// tb_user_write_arbiter: directed self-checking bench for user_write_arbiter.
module tb_user_write_arbiter;
    logic        clk = 0;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_usr_id;
    logic [7:0]  out_data;
    logic        deny_pulse;
    logic        busy;
`ifdef VIOLATION_LOG_EN
    logic [7:0]  viol_count;
    logic [1:0]  last_viol_id;
    logic        viol_clr;
`endif

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    user_write_arbiter dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .out_valid(out_valid), .out_ready(out_ready),
        .out_usr_id(out_usr_id), .out_data(out_data), .deny_pulse(deny_pulse), .busy(busy)
`ifdef VIOLATION_LOG_EN
        , .viol_count(viol_count), .last_viol_id(last_viol_id), .viol_clr(viol_clr)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    initial begin
        logic [1:0] e;
        rst_n = 0; req_valid = 0; req_data = 0; out_ready = 0;
`ifdef VIOLATION_LOG_EN
        viol_clr = 0;
`endif
        tick(); tick();
        check("rst out_valid", out_valid, 0);
        check("rst busy", busy, 0);
        check("rst deny", deny_pulse, 0);
        check("rst req_ready", req_ready, 0);
        check("rst out_data", out_data, 0);
        check("rst usr_id", out_usr_id, 0);
`ifdef VIOLATION_LOG_EN
        check("rst viol_count", viol_count, 0);
        check("rst last_viol_id", last_viol_id, 0);
`endif
        rst_n = 1;

        // authorized single write from port 2
        req_valid = 4'b0100; req_data = 32'h00A5_0000; out_ready = 1; #1;
        check("t1 req_ready", req_ready, 4'b0100);
        tick(); req_valid = 0; #1;
        check("t1 out_valid", out_valid, 1);
        check("t1 usr_id", out_usr_id, 2);
        check("t1 out_data", out_data, 8'hA5);
        check("t1 busy", busy, 1);
        check("t1 ready idle", req_ready, 0);
        tick();
        check("t1 out_valid low", out_valid, 0);

        // denied write from port 0 (rr_ptr=3 wraps to 0)
        req_valid = 4'b0001; req_data = 32'h0000_003C; #1;
        check("t2 req_ready", req_ready, 4'b0001);
        tick(); req_valid = 0; #1;
        check("t2 deny", deny_pulse, 1);
        check("t2 out_valid", out_valid, 0);
        check("t2 out_data", out_data, 0);
        check("t2 usr_id", out_usr_id, 0);
        tick();
        check("t2 deny end", deny_pulse, 0);
        check("t2 busy end", busy, 0);
        check("t2 out_valid end", out_valid, 0);

        // reset returns rr_ptr to 0, then all ports contend
        rst_n = 0; tick(); rst_n = 1;
        req_valid = 4'b1111; req_data = 32'h1312_1110; #1;
        for (int i = 0; i < 5; i++) begin
            e = 2'(i % 4);
            check($sformatf("t3 grant%0d", i), req_ready, 4'b0001 << e);
            tick();
            check($sformatf("t3 hold%0d", i), req_ready, 0);
            check($sformatf("t3 valid%0d", i), out_valid, e == 2);
            check($sformatf("t3 deny%0d", i), deny_pulse, e != 2);
            check($sformatf("t3 data%0d", i), out_data, e == 2 ? 8'h12 : 8'h00);
            check($sformatf("t3 id%0d", i), out_usr_id, e);
            tick();
        end
        req_valid = 0;

        // backpressure: rr_ptr=1, port 2 wins, held while out_ready=0
        req_valid = 4'b0100; req_data = 32'h005A_0000; out_ready = 0; #1;
        check("t4 req_ready", req_ready, 4'b0100);
        tick(); req_valid = 4'b1011;
        for (int i = 0; i < 5; i++) begin
            #1;
            check($sformatf("t4 valid%0d", i), out_valid, 1);
            check($sformatf("t4 data%0d", i), out_data, 8'h5A);
            check($sformatf("t4 ready%0d", i), req_ready, 0);
            tick();
        end
        out_ready = 1; req_valid = 0; #1;
        check("t4 valid at accept", out_valid, 1);
        tick();
        check("t4 valid done", out_valid, 0);
        check("t4 busy done", busy, 0);

        // reset during SEND
        req_valid = 4'b0100; out_ready = 0; tick(); req_valid = 0;
        check("t5 in send", out_valid, 1);
        rst_n = 0; tick(); rst_n = 1;
        check("t5 valid", out_valid, 0);
        check("t5 busy", busy, 0);
        check("t5 data", out_data, 0);
        req_valid = 4'b1111; #1;
        check("t5 rr_ptr", req_ready, 4'b0001);
        tick(); req_valid = 0; tick();
        check("t5 no replay", out_valid, 0);

`ifdef VIOLATION_LOG_EN
        check("t6 count1", viol_count, 1);
        check("t6 last0", last_viol_id, 0);
        // clear wins over a simultaneous deny entry
        req_valid = 4'b1000; viol_clr = 1; tick(); viol_clr = 0; req_valid = 0;
        check("t6 clr wins", viol_count, 0);
        check("t6 last3", last_viol_id, 3);
        tick();
        req_valid = 4'b1000;
        for (int i = 0; i < 600; i++) tick();
        req_valid = 0; tick();
        check("t6 saturate", viol_count, 8'hFF);
        check("t6 last id", last_viol_id, 3);
        viol_clr = 1; tick(); viol_clr = 0;
        check("t6 cleared", viol_count, 0);
        check("t6 last kept", last_viol_id, 3);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
